// File: rtl/ralu_pkg.sv
// Shared widths, ALU opcodes and load-vector bit positions for the 4-bit register ALU.
package ralu_pkg;

  localparam int DATA_W     = 4;
  localparam int ADR_W      = 3;
  localparam int GPRB_DEPTH = 8;

  // logic/shift mode (M=0)
  localparam logic [3:0] OP_L_A    = 4'b0000;
  localparam logic [3:0] OP_L_B    = 4'b0001;
  localparam logic [3:0] OP_L_NA   = 4'b0010;
  localparam logic [3:0] OP_L_NB   = 4'b0011;
  localparam logic [3:0] OP_L_AND  = 4'b0100;
  localparam logic [3:0] OP_L_SHLB = 4'b0101;
  localparam logic [3:0] OP_L_SHRB = 4'b0110;
  localparam logic [3:0] OP_L_OR   = 4'b0111;
  localparam logic [3:0] OP_L_XOR  = 4'b1000;
  localparam logic [3:0] OP_L_NAND = 4'b1001;
  localparam logic [3:0] OP_L_NOR  = 4'b1010;
  localparam logic [3:0] OP_L_XNOR = 4'b1011;
  localparam logic [3:0] OP_L_SHLA = 4'b1100;
  localparam logic [3:0] OP_L_SHRA = 4'b1101;
  localparam logic [3:0] OP_L_ZERO = 4'b1110;
  localparam logic [3:0] OP_L_ONES = 4'b1111;

  // arithmetic mode (M=1)
  localparam logic [3:0] OP_A_INCA = 4'b0000;
  localparam logic [3:0] OP_A_INCB = 4'b0001;
  localparam logic [3:0] OP_A_DECA = 4'b0010;
  localparam logic [3:0] OP_A_DECB = 4'b0011;
  localparam logic [3:0] OP_A_DBLA = 4'b0100;
  localparam logic [3:0] OP_A_DBLB = 4'b0101;
  localparam logic [3:0] OP_A_AMB  = 4'b0110;
  localparam logic [3:0] OP_A_BMA  = 4'b0111;
  localparam logic [3:0] OP_A_NA   = 4'b1000;
  localparam logic [3:0] OP_A_ADD  = 4'b1001;
  localparam logic [3:0] OP_A_NB   = 4'b1010;

  localparam int V_LDA  = 0;
  localparam int V_LDB  = 1;
  localparam int V_BSRC = 2;
  localparam int V_ARES = 3;

endpackage

// File: rtl/ralu_alu.sv
// Combinational ALU: logic/shift functions for M=0, 5-bit adder forms for M=1.
module ralu_alu
  import ralu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        s,
  input  logic              m,
  input  logic              pin,
  input  logic              isr,
  input  logic              isl,
  output logic [DATA_W-1:0] r,
  output logic              pout,
  output logic              osr,
  output logic              osl
);

  logic [DATA_W-1:0] add_x_s;
  logic [DATA_W-1:0] add_y_s;
  logic              add_en_s;
  logic [DATA_W:0]   sum_s;

  assign sum_s = {1'b0, add_x_s} + {1'b0, add_y_s} + {4'b0000, pin};

  // operation decode; arithmetic ops only pick adder operands
  always_comb begin
    r        = 4'b0000;
    pout     = 1'b0;
    osr      = 1'b0;
    osl      = 1'b0;
    add_x_s  = 4'b0000;
    add_y_s  = 4'b0000;
    add_en_s = 1'b0;
    if (!m) begin
      case (s)
        OP_L_A:    r = a;
        OP_L_B:    r = b;
        OP_L_NA:   r = ~a;
        OP_L_NB:   r = ~b;
        OP_L_AND:  r = a & b;
        OP_L_SHLB: begin r = {b[2:0], isl}; osl = b[3]; end
        OP_L_SHRB: begin r = {isr, b[3:1]}; osr = b[0]; end
        OP_L_OR:   r = a | b;
        OP_L_XOR:  r = a ^ b;
        OP_L_NAND: r = ~(a & b);
        OP_L_NOR:  r = ~(a | b);
        OP_L_XNOR: r = ~(a ^ b);
        OP_L_SHLA: begin r = {a[2:0], isl}; osl = a[3]; end
        OP_L_SHRA: begin r = {isr, a[3:1]}; osr = a[0]; end
        OP_L_ZERO: r = 4'b0000;
        OP_L_ONES: r = 4'b1111;
        default:   r = 4'b0000;
      endcase
    end else begin
      add_en_s = 1'b1;
      case (s)
        OP_A_INCA: add_x_s = a;
        OP_A_INCB: add_x_s = b;
        OP_A_DECA: begin add_x_s = a; add_y_s = 4'b1111; end
        OP_A_DECB: begin add_x_s = b; add_y_s = 4'b1111; end
        OP_A_DBLA: begin add_x_s = a; add_y_s = a; end
        OP_A_DBLB: begin add_x_s = b; add_y_s = b; end
        OP_A_AMB:  begin add_x_s = a; add_y_s = ~b; end
        OP_A_BMA:  begin add_x_s = b; add_y_s = ~a; end
        OP_A_NA:   add_x_s = ~a;
        OP_A_ADD:  begin add_x_s = a; add_y_s = b; end
        OP_A_NB:   add_x_s = ~b;
        default:   add_en_s = 1'b0;
      endcase
      if (add_en_s) begin
        r    = sum_s[DATA_W-1:0];
        pout = sum_s[DATA_W];
      end else begin
        r    = 4'b0000;
        pout = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ralu_core.sv
// Register ALU datapath: A/B operand registers, 8x4 register bank, ALU result feedback.
module ralu_core
  import ralu_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] DataIn,
  input  logic [3:0]        S,
  input  logic              M,
  input  logic              Pin,
  input  logic              ISR,
  input  logic              ISL,
  input  logic              A,
  input  logic              wr,
  input  logic [ADR_W-1:0]  adr,
  input  logic [3:0]        v,
  output logic              OSR,
  output logic              OSL,
  output logic              Pout,
  output logic [DATA_W-1:0] R
);

  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic [DATA_W-1:0] gprb_r [GPRB_DEPTH];
  logic [DATA_W-1:0] rd_s;

  assign rd_s = gprb_r[adr];

  ralu_alu u_alu (
    .a    (a_r),
    .b    (b_r),
    .s    (S),
    .m    (M),
    .pin  (Pin),
    .isr  (ISR),
    .isl  (ISL),
    .r    (R),
    .pout (Pout),
    .osr  (OSR),
    .osl  (OSL)
  );

  // operand A: ALU result has priority over the external/bank load
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_r <= 4'b0000;
    end else if (v[V_ARES]) begin
      a_r <= R;
    end else if (v[V_LDA]) begin
      a_r <= A ? DataIn : rd_s;
    end else begin
      a_r <= a_r;
    end
  end

  // operand B: source bit is only meaningful together with the load bit
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      b_r <= 4'b0000;
    end else if (v[V_LDB]) begin
      b_r <= v[V_BSRC] ? rd_s : R;
    end else begin
      b_r <= b_r;
    end
  end

  // register bank, written only from the ALU result
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < GPRB_DEPTH; i++) gprb_r[i] <= 4'b0000;
    end else if (wr) begin
      gprb_r[adr] <= R;
    end else begin
      gprb_r <= gprb_r;
    end
  end

endmodule

// File: tb/tb_ralu_core.sv
// Directed-vector bench for ralu_core; expected values are hand-computed constants.
module tb_ralu_core;
  import ralu_pkg::*;

  logic       clock;
  logic       reset;
  logic [3:0] DataIn;
  logic [3:0] S;
  logic       M;
  logic       Pin;
  logic       ISR;
  logic       ISL;
  logic       A;
  logic       wr;
  logic [2:0] adr;
  logic [3:0] v;
  logic       OSR;
  logic       OSL;
  logic       Pout;
  logic [3:0] R;

  int n_checks = 0;
  int n_fail   = 0;

  ralu_core dut (
    .clock  (clock),
    .reset  (reset),
    .DataIn (DataIn),
    .S      (S),
    .M      (M),
    .Pin    (Pin),
    .ISR    (ISR),
    .ISL    (ISL),
    .A      (A),
    .wr     (wr),
    .adr    (adr),
    .v      (v),
    .OSR    (OSR),
    .OSL    (OSL),
    .Pout   (Pout),
    .R      (R)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    v  = 4'b0000;
    wr = 1'b0;
  endtask

  // R shows A when S=0000, M=0
  task automatic chk_a(input string tag, input logic [3:0] exp);
    S = 4'b0000; M = 1'b0; #1;
    check(tag, {4'h0, R}, {4'h0, exp});
  endtask

  task automatic chk_b(input string tag, input logic [3:0] exp);
    S = 4'b0001; M = 1'b0; #1;
    check(tag, {4'h0, R}, {4'h0, exp});
  endtask

  task automatic load_a_ext(input logic [3:0] d);
    DataIn = d; A = 1'b1; v = 4'b0001;
    tick();
  endtask

  task automatic load_a_bank(input logic [2:0] ad);
    A = 1'b0; adr = ad; v = 4'b0001;
    tick();
  endtask

  // B <= A through R (S=0000, M=0)
  task automatic copy_a_to_b();
    S = 4'b0000; M = 1'b0; v = 4'b0010;
    tick();
  endtask

  initial begin
    reset = 1'b0; DataIn = 4'h0; S = 4'b0000; M = 1'b0; Pin = 1'b0;
    ISR = 1'b0; ISL = 1'b0; A = 1'b0; wr = 1'b0; adr = 3'd0; v = 4'b0000;
    #12;
    check("rst_r", {4'h0, R}, 8'h00);
    check("rst_pout", {7'h0, Pout}, 8'h00);
    chk_b("rst_b", 4'h0);
    @(negedge clock);
    reset = 1'b1;

    // reset then load
    load_a_ext(4'd3);
    chk_a("ld_a3", 4'd3);
    wr = 1'b1; adr = 3'd0; S = 4'b0000; M = 1'b0;
    tick();

    // bank round-trip
    load_a_ext(4'd12);
    chk_a("ld_a12", 4'd12);
    wr = 1'b1; adr = 3'd1;
    tick();
    load_a_bank(3'd0);
    chk_a("bank0_to_a", 4'd3);
    adr = 3'd1; v = 4'b0110;
    tick();
    chk_b("bank1_to_b", 4'd12);

    // add with bank write
    M = 1'b1; S = 4'b1001; Pin = 1'b0; #1;
    check("add_r", {4'h0, R}, 8'd15);
    check("add_pout", {7'h0, Pout}, 8'h00);
    wr = 1'b1; adr = 3'd1;
    tick();
    load_a_ext(4'd1);
    copy_a_to_b();
    load_a_ext(4'd15);
    M = 1'b1; S = 4'b1001; Pin = 1'b0; #1;
    check("add_wrap_r", {4'h0, R}, 8'h00);
    check("add_wrap_pout", {7'h0, Pout}, 8'h01);
    M = 1'b1; S = 4'b1011; #1;
    check("arith_unused_r", {3'h0, Pout, R}, 8'h00);

    // shift chain on B
    load_a_ext(4'd3);
    copy_a_to_b();
    M = 1'b0; S = 4'b0101; ISL = 1'b0; v = 4'b0010; #1;
    check("shl1_r", {3'h0, OSL, R}, {3'h0, 1'b0, 4'd6});
    tick();
    S = 4'b0101; v = 4'b0010; #1;
    check("shl2_r", {3'h0, OSL, R}, {3'h0, 1'b0, 4'd12});
    tick();
    S = 4'b0101; v = 4'b0010; wr = 1'b1; adr = 3'd0; #1;
    check("shl3_r", {3'h0, OSL, R}, {3'h0, 1'b1, 4'd8});
    tick();
    chk_b("shl_b", 4'd8);
    S = 4'b0110; ISR = 1'b1; #1;
    check("shr_b", {3'h0, OSR, R}, {3'h0, 1'b0, 4'd12});
    ISR = 1'b0;

    // logic ops (also proves GPRB[1]=15 was written by the add)
    load_a_bank(3'd1);
    chk_a("bank1_sum", 4'd15);
    S = 4'b0100; #1;
    check("and_r", {4'h0, R}, 8'd8);
    S = 4'b1000; #1;
    check("xor_r", {4'h0, R}, 8'd7);
    S = 4'b1111; #1;
    check("ones_r", {4'h0, R}, 8'd15);
    load_a_bank(3'd0);
    chk_a("bank0_shift", 4'd8);

    // subtract 5 - 7
    load_a_ext(4'd7);
    copy_a_to_b();
    load_a_ext(4'd5);
    M = 1'b1; S = 4'b0110; Pin = 1'b1; #1;
    check("sub_r", {4'h0, R}, 8'd14);
    check("sub_pout", {7'h0, Pout}, 8'h00);
    Pin = 1'b0;

    // read-during-write returns the old bank value; A=5 so R=5 is written
    S = 4'b0000; M = 1'b0; wr = 1'b1; A = 1'b0; adr = 3'd2; v = 4'b0001;
    tick();
    chk_a("rdw_old", 4'd0);
    load_a_bank(3'd2);
    chk_a("rdw_new", 4'd5);

    // v[3] priority over v[0]
    DataIn = 4'd3; A = 1'b1; M = 1'b0; S = 4'b1110; v = 4'b1001;
    tick();
    chk_a("ares_prio", 4'd0);

    // mid-sequence reset with a write pending
    load_a_ext(4'd9);
    copy_a_to_b();
    S = 4'b0000; wr = 1'b1; adr = 3'd3;
    #2;
    reset = 1'b0;
    #1;
    chk_a("midrst_a", 4'd0);
    chk_b("midrst_b", 4'd0);
    @(negedge clock);
    reset = 1'b1;
    wr = 1'b0;
    load_a_bank(3'd1);
    chk_a("midrst_g1", 4'd0);
    load_a_bank(3'd3);
    chk_a("midrst_g3", 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ralu_core.md
Name: ralu_core

Overview:
- 4-bit register ALU: operand registers A and B, an 8x4 general-purpose register bank (GPRB), and a combinational ALU with logic, shift and arithmetic operations.
- ALU result R feeds back to B and A and is the only GPRB write source.
- Datapath slice of the central unit; all sequencing comes from the external control word (S, M, Pin, A, wr, adr, v).

Parameters:
- none; widths fixed: data 4, GPRB depth 8, address 3.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- DataIn  in  4  external data for register A.
- S  in  4  ALU operation select.
- M  in  1  mode: 0 = logic/shift, 1 = arithmetic.
- Pin  in  1  carry-in, arithmetic mode only.
- ISR  in  1  serial bit entering MSB on right shifts.
- ISL  in  1  serial bit entering LSB on left shifts.
- A  in  1  register-A source select: 1 = DataIn, 0 = GPRB[adr].
- wr  in  1  GPRB write enable.
- adr  in  3  GPRB address, shared by read and write.
- v  in  4  register load vector (see Behaviour).
- OSR  out  1  bit shifted out on right shifts.
- OSL  out  1  bit shifted out on left shifts.
- Pout  out  1  carry-out.
- R  out  4  ALU result, combinational.

Behaviour:
- Reset (reset=0, async): A, B and all 8 GPRB entries = 0. R, Pout, OSR and OSL follow combinationally; with S=0000 and M=0, R=0.
- All state updates on rising clock edge. R, Pout, OSR and OSL are combinational from A, B, S, M, Pin, ISR and ISL; zero latency.
- GPRB reads are asynchronous (GPRB[adr]). Any read in the same cycle as a write returns the pre-write value.
- Register A update, in priority order:
  - v[3]=1: A <= R.
  - else v[0]=1: A <= (A input ? DataIn : GPRB[adr]).
  - else A holds.
- Register B update:
  - v[1]=1: B <= (v[2] ? GPRB[adr] : R).
  - v[1]=0: B holds. v[2] alone has no effect.
- GPRB: wr=1 writes GPRB[adr] <= R. It may coincide with A/B loads; every destination samples the same pre-edge R.
- M=0 (Pout=0; OSL and OSR=0 unless the op is a shift):
  - 0000 A; 0001 B; 0010 ~A; 0011 ~B; 0100 A&B.
  - 0101 B shift left: {B[2:0],ISL}, OSL=B[3].
  - 0110 B shift right: {ISR,B[3:1]}, OSR=B[0].
  - 0111 A|B; 1000 A^B; 1001 ~(A&B); 1010 ~(A|B); 1011 ~(A^B).
  - 1100 A shift left: {A[2:0],ISL}, OSL=A[3].
  - 1101 A shift right: {ISR,A[3:1]}, OSR=A[0].
  - 1110 0000; 1111 1111.
- M=1: 5-bit sum; R = sum[3:0], Pout = sum[4]; OSL=OSR=0.
  - 0000 A+Pin; 0001 B+Pin; 0010 A+1111+Pin; 0011 B+1111+Pin.
  - 0100 A+A+Pin; 0101 B+B+Pin.
  - 0110 A+~B+Pin (subtract; Pin=1 means no borrow); 0111 B+~A+Pin.
  - 1000 ~A+Pin; 1001 A+B+Pin; 1010 ~B+Pin.
  - 1011–1111: R=0, Pout=0.
- Arithmetic wraps modulo 16; overflow is reported only via Pout.
- Reset asserted mid-sequence clears all state immediately; pending writes are discarded.

Decomposition:
- Shared package ralu_pkg holds:
  - width constants DATA_W=4, ADR_W=3, GPRB_DEPTH=8;
  - ALU opcode localparams for both modes;
  - v bit-index constants V_LDA=0, V_LDB=1, V_BSRC=2, V_ARES=3.
- One sub-module, ralu_alu: the combinational S/M/Pin/ISR/ISL function producing R, Pout, OSR and OSL.
- Registers and GPRB stay in the top level.

Test Plan:
- Reset then load: reset=0 -> A=B=0, R=0. Release; DataIn=3, A=1, v=0001 -> A=3. Next cycle wr=1, adr=0, S=0000, M=0 -> GPRB[0]=3.
- Bank round-trip: DataIn=12 into A, then wr to adr 1. Then A=0, v=0001, adr=0 -> A=3. Then v=0110, adr=1 -> B=12.
- Add: A=3, B=12, M=1, S=1001, Pin=0, wr=1, adr=1 -> R=15, Pout=0, GPRB[1]=15. Also A=15, B=1 -> R=0, Pout=1.
- Shift chain: B=3; three cycles with M=0, S=0101, v=0010, ISL=0 -> B=6, 12, 8. Third cycle OSL=1; with wr=1, adr=0 it also writes GPRB[0]=8.
- Logic: A<=GPRB[1]=15, B=8, M=0, S=0100 -> R=8. S=1000 -> R=7. Subtract M=1, S=0110, Pin=1, A=5, B=7 -> R=14, Pout=0.
- Hazards: wr=1 with v=0001 on the same adr -> A gets the old GPRB value. Reset pulsed mid-sequence -> all registers and GPRB read 0 immediately.
